dma_reg_slave: RTL and testbench

DMA_REG_SLAVE -- requirements
Module: dma_reg_slave

---
 rtl/config_pkg.sv | 8 +
 rtl/dma_pkg.sv | 27 ++
 rtl/DATA_BUS.sv | 14 +
 rtl/dma_desc_fifo.sv | 51 +++++
 rtl/dma_reg_slave.sv | 139 +++++++++++++
 tb/tb_dma_reg_slave.sv | 219 +++++++++++++++++++++
 6 files changed

// File: rtl/config_pkg.sv
// Shared SoC configuration: bus address map entries for the DMA register slave.
package config_pkg;

  localparam logic [31:0] CFG_BADR_DMA = 32'h8000_0000;
  localparam logic [31:0] CFG_MADR_DMA = 32'hFFFF_FFE0;
  localparam int unsigned CFG_DMA      = 3;

endpackage

// File: rtl/dma_pkg.sv
// DMA register slave definitions: register map, bit positions, descriptor and engine state.
package dma_pkg;

  // Word offsets, decoded from addr[4:2]
  localparam logic [2:0] REG_SRC    = 3'd0;
  localparam logic [2:0] REG_DST    = 3'd1;
  localparam logic [2:0] REG_LEN    = 3'd2;
  localparam logic [2:0] REG_CTRL   = 3'd3;
  localparam logic [2:0] REG_STATUS = 3'd4;

  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_BUSY = 0;
  localparam int unsigned STAT_DONE = 1;
  localparam int unsigned STAT_QCNT = 2;
  localparam int unsigned STAT_ERR  = 4;

  typedef struct packed {
    logic [31:0] src;
    logic [31:0] dst;
    logic [15:0] len;
  } dma_desc_t;

  typedef enum logic {StIdle, StActive} dma_state_e;

endpackage

// File: rtl/DATA_BUS.sv
// Simple single-cycle request / one-cycle-later ack data bus.
interface DATA_BUS;

  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;

  modport slave  (input req, we, addr, wdata, output rdata, ack);
  modport master (output req, we, addr, wdata, input rdata, ack);

endinterface

// File: rtl/dma_desc_fifo.sv
// Two-entry descriptor FIFO with 1-bit wrapping pointers and an occupancy count.
module dma_desc_fifo
  import dma_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  dma_desc_t push_data,
  input  logic      pop,
  output dma_desc_t head,
  output logic [1:0] count
);

  logic      wr_ptr_q, rd_ptr_q;
  logic [1:0] count_q, count_d;
  dma_desc_t mem_q [2];
  logic      push_ok, pop_ok;

  // Guard against overflow/underflow; a push+pop at count 1 keeps order via the pointers
  always_comb begin
    push_ok = push && (count_q != 2'd2);
    pop_ok  = pop && (count_q != 2'd0);
    count_d = count_q;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // Storage, pointers and count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= push_data;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/dma_reg_slave.sv
// DMA register slave: bus-programmed descriptor queue feeding a DMA engine, with status/irq.
module dma_reg_slave
  import config_pkg::*;
  import dma_pkg::*;
#(
  parameter logic [31:0] base_addr = CFG_BADR_DMA,
  parameter logic [31:0] addr_mask = CFG_MADR_DMA
) (
  input  logic        clk,
  input  logic        rst,
  DATA_BUS.slave      dslv,
  output logic        desc_valid,
  input  logic        desc_ready,
  output logic [31:0] desc_src,
  output logic [31:0] desc_dst,
  output logic [15:0] desc_len,
  input  logic        xfer_done,
  output logic        irq
);

  dma_state_e  state_q, state_d;
  logic [31:0] src_q, src_d, dst_q, dst_d;
  logic [15:0] len_q, len_d;
  logic        irq_en_q, irq_en_d, done_q, done_d, err_q, err_d, irq_q;
  logic        ack_q;
  logic [31:0] rdata_q, rd_data;
  logic        sel, wr, start, push, pop, done_set;
  logic [2:0]  offset;
  logic [1:0]  qcount;
  logic        busy;
  dma_desc_t   head, new_desc;

  dma_desc_fifo u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (new_desc),
    .pop       (pop),
    .head      (head),
    .count     (qcount)
  );

  // Address decode, queue control and engine tracking next-state
  always_comb begin
    sel      = dslv.req && ((dslv.addr & addr_mask) == base_addr);
    offset   = dslv.addr[4:2];
    wr       = sel && dslv.we;
    start    = wr && (offset == REG_CTRL) && dslv.wdata[CTRL_START];
    // Full check uses the pre-dequeue count, so a same-cycle pop does not rescue the start
    push     = start && (len_q != 16'd0) && (qcount != 2'd2);
    new_desc = '{src: src_q, dst: dst_q, len: len_q};
    busy     = (state_q == StActive) || (qcount != 2'd0);
    desc_valid = (qcount != 2'd0) && (state_q == StIdle);
    pop      = desc_valid && desc_ready;
    done_set = 1'b0;
    state_d  = state_q;
    unique case (state_q)
      StIdle:   if (pop) state_d = StActive;
      StActive: if (xfer_done) begin
        state_d  = StIdle;
        done_set = 1'b1;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Register file next-state; sticky sets win over W1C clears
  always_comb begin
    src_d    = src_q;
    dst_d    = dst_q;
    len_d    = len_q;
    irq_en_d = irq_en_q;
    done_d   = done_q;
    err_d    = err_q;
    if (wr) begin
      unique case (offset)
        REG_SRC:    src_d    = dslv.wdata;
        REG_DST:    dst_d    = dslv.wdata;
        REG_LEN:    len_d    = dslv.wdata[15:0];
        REG_CTRL:   irq_en_d = dslv.wdata[CTRL_IRQ_EN];
        REG_STATUS: begin
          if (dslv.wdata[STAT_DONE]) done_d = 1'b0;
          if (dslv.wdata[STAT_ERR])  err_d  = 1'b0;
        end
        default: ;
      endcase
    end
    if (done_set) done_d = 1'b1;
    if (start && !push) err_d = 1'b1;
  end

  // Read data mux
  always_comb begin
    rd_data = 32'd0;
    case (offset)
      REG_SRC:    rd_data = src_q;
      REG_DST:    rd_data = dst_q;
      REG_LEN:    rd_data = {16'd0, len_q};
      REG_CTRL:   rd_data = {30'd0, irq_en_q, 1'b0};
      REG_STATUS: rd_data = {27'd0, err_q, qcount, done_q, busy};
      default:    rd_data = 32'd0;
    endcase
  end

  // State, registers, bus response and irq
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      src_q    <= 32'd0;
      dst_q    <= 32'd0;
      len_q    <= 16'd0;
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_q    <= 1'b0;
      ack_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      irq_en_q <= irq_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_q    <= irq_en_q && (done_q || err_q);
      ack_q    <= sel;
      rdata_q  <= sel ? rd_data : 32'd0;
    end
  end

  assign dslv.ack   = ack_q;
  assign dslv.rdata = rdata_q;
  assign desc_src   = head.src;
  assign desc_dst   = head.dst;
  assign desc_len   = head.len;
  assign irq        = irq_q;

endmodule

// File: tb/tb_dma_reg_slave.sv
// Directed self-checking bench for dma_reg_slave.
module tb_dma_reg_slave;
  import config_pkg::*;
  import dma_pkg::*;

  localparam logic [31:0] Base = CFG_BADR_DMA;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_ready = 1'b0;
  logic        xfer_done = 1'b0;
  logic        desc_valid, irq;
  logic [31:0] desc_src, desc_dst;
  logic [15:0] desc_len;
  logic [31:0] rd;
  int          n_cmp = 0;
  int          n_bad = 0;

  DATA_BUS bus ();

  dma_reg_slave dut (
    .clk        (clk),
    .rst        (rst),
    .dslv       (bus),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_src   (desc_src),
    .desc_dst   (desc_dst),
    .desc_len   (desc_len),
    .xfer_done  (xfer_done),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] addr_of(input logic [2:0] off);
    return Base + {27'd0, off, 2'b00};
  endfunction

  task automatic bus_write(input logic [2:0] off, input logic [31:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = addr_of(off); bus.wdata = d;
    @(negedge clk);
    bus.req = 1'b0; bus.we = 1'b0;
    check("wr_ack", {31'd0, bus.ack}, 32'd1);
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [31:0] d);
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b0; bus.addr = addr_of(off);
    @(negedge clk);
    bus.req = 1'b0;
    check("rd_ack", {31'd0, bus.ack}, 32'd1);
    d = bus.rdata;
  endtask

  task automatic pulse_ready();
    @(negedge clk); desc_ready = 1'b1;
    @(negedge clk); desc_ready = 1'b0;
  endtask

  task automatic pulse_done();
    @(negedge clk); xfer_done = 1'b1;
    @(negedge clk); xfer_done = 1'b0;
  endtask

  initial begin
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = 32'd0; bus.wdata = 32'd0;
    #12;
    check("rst_valid", {31'd0, desc_valid}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_rdata", bus.rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    bus_read(REG_STATUS, rd); check("rst_status", rd, 32'h0);

    // Out-of-window access: no ack, no state change
    @(negedge clk);
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = Base + 32'h100; bus.wdata = 32'hDEAD;
    @(negedge clk); bus.req = 1'b0; bus.we = 1'b0;
    check("unsel_ack", {31'd0, bus.ack}, 32'd0);
    bus_read(REG_SRC, rd); check("unsel_src", rd, 32'h0);

    // First descriptor
    bus_write(REG_SRC, 32'h100);
    bus_write(REG_DST, 32'h200);
    bus_write(REG_LEN, 32'hFFFF_0004);
    bus_write(REG_CTRL, 32'h1);
    check("a_valid", {31'd0, desc_valid}, 32'd1);
    check("a_src", desc_src, 32'h100);
    check("a_dst", desc_dst, 32'h200);
    check("a_len", {16'd0, desc_len}, 32'd4);
    bus_read(REG_STATUS, rd); check("a_status", rd, 32'h5);
    bus_read(REG_LEN, rd); check("len_upper", rd, 32'h4);
    bus_read(REG_CTRL, rd); check("ctrl_rd", rd, 32'h0);

    // Back-to-back reads, each acked
    @(negedge clk); bus.req = 1'b1; bus.we = 1'b0; bus.addr = addr_of(REG_SRC);
    @(negedge clk); bus.addr = addr_of(REG_DST);
    check("b2b_ack0", {31'd0, bus.ack}, 32'd1);
    check("b2b_rd0", bus.rdata, 32'h100);
    @(negedge clk); bus.req = 1'b0;
    check("b2b_ack1", {31'd0, bus.ack}, 32'd1);
    check("b2b_rd1", bus.rdata, 32'h200);
    @(negedge clk);
    check("b2b_ack_end", {31'd0, bus.ack}, 32'd0);
    check("b2b_rd_end", bus.rdata, 32'h0);

    // Unmapped offsets read 0, writes ignored but acked
    bus_write(3'd6, 32'hFFFF_FFFF);
    bus_read(3'd6, rd); check("unmapped6", rd, 32'h0);
    bus_read(3'd7, rd); check("unmapped7", rd, 32'h0);

    // Second descriptor, then overflow
    bus_write(REG_SRC, 32'h300);
    bus_write(REG_DST, 32'h400);
    bus_write(REG_LEN, 32'h8);
    bus_write(REG_CTRL, 32'h1);
    bus_write(REG_CTRL, 32'h1);
    bus_read(REG_STATUS, rd); check("ovf_status", rd, 32'h19);
    check("ovf_head", desc_src, 32'h100);
    bus_write(REG_CTRL, 32'h2);
    check("irq_lag", {31'd0, irq}, 32'd0);
    @(negedge clk);
    check("irq_on", {31'd0, irq}, 32'd1);
    bus_write(REG_STATUS, 32'h10);
    check("irq_clr_lag", {31'd0, irq}, 32'd1);
    bus_read(REG_STATUS, rd); check("err_clr", rd, 32'h9);
    check("irq_off", {31'd0, irq}, 32'd0);

    // Dequeue in order, done tracking
    pulse_ready();
    check("deq1_valid", {31'd0, desc_valid}, 32'd0);
    check("deq1_head", desc_src, 32'h300);
    bus_read(REG_STATUS, rd); check("deq1_status", rd, 32'h5);
    pulse_done();
    check("b_valid", {31'd0, desc_valid}, 32'd1);
    check("b_dst", desc_dst, 32'h400);
    check("b_len", {16'd0, desc_len}, 32'd8);
    bus_read(REG_STATUS, rd); check("done1_status", rd, 32'h7);
    check("done_irq", {31'd0, irq}, 32'd1);
    pulse_ready();
    bus_read(REG_STATUS, rd); check("deq2_status", rd, 32'h3);
    pulse_done();
    bus_read(REG_STATUS, rd); check("done2_status", rd, 32'h2);
    pulse_done();
    bus_read(REG_STATUS, rd); check("idle_done_ign", rd, 32'h2);
    bus_write(REG_STATUS, 32'h2);
    bus_read(REG_STATUS, rd); check("done_w1c", rd, 32'h0);

    // Zero-length start
    bus_write(REG_LEN, 32'h0);
    bus_write(REG_CTRL, 32'h3);
    check("len0_valid", {31'd0, desc_valid}, 32'd0);
    bus_read(REG_STATUS, rd); check("len0_status", rd, 32'h10);
    bus_read(REG_CTRL, rd); check("ctrl_irq_en", rd, 32'h2);
    bus_write(REG_STATUS, 32'h10);

    // Start coincident with dequeue at count 1
    bus_write(REG_SRC, 32'h500);
    bus_write(REG_DST, 32'h600);
    bus_write(REG_LEN, 32'h5);
    bus_write(REG_CTRL, 32'h3);
    check("c_src", desc_src, 32'h500);
    bus_write(REG_SRC, 32'h700);
    bus_write(REG_DST, 32'h800);
    @(negedge clk);
    desc_ready = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = addr_of(REG_CTRL); bus.wdata = 32'h3;
    @(negedge clk);
    desc_ready = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    check("sim_valid", {31'd0, desc_valid}, 32'd0);
    check("sim_src", desc_src, 32'h700);
    check("sim_dst", desc_dst, 32'h800);
    bus_read(REG_STATUS, rd); check("sim_status", rd, 32'h5);

    // DONE W1C coincident with the completing xfer_done
    @(negedge clk);
    xfer_done = 1'b1;
    bus.req = 1'b1; bus.we = 1'b1; bus.addr = addr_of(REG_STATUS); bus.wdata = 32'h2;
    @(negedge clk);
    xfer_done = 1'b0; bus.req = 1'b0; bus.we = 1'b0;
    bus_read(REG_STATUS, rd); check("done_set_wins", rd, 32'h7);
    check("d_valid", {31'd0, desc_valid}, 32'd1);
    check("d_src", desc_src, 32'h700);

    // Reset mid-ACTIVE with a queued descriptor
    pulse_ready();
    bus_write(REG_CTRL, 32'h3);
    @(negedge clk);
    check("pre_rst_irq", {31'd0, irq}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("arst_valid", {31'd0, desc_valid}, 32'd0);
    check("arst_src", desc_src, 32'h0);
    check("arst_dst", desc_dst, 32'h0);
    check("arst_len", {16'd0, desc_len}, 32'h0);
    check("arst_irq", {31'd0, irq}, 32'd0);
    check("arst_ack", {31'd0, bus.ack}, 32'd0);
    @(negedge clk); rst = 1'b1;
    pulse_done();
    bus_read(REG_STATUS, rd); check("post_rst_status", rd, 32'h0);
    check("post_rst_valid", {31'd0, desc_valid}, 32'd0);
    bus_read(REG_SRC, rd); check("post_rst_src", rd, 32'h0);
    bus_read(REG_CTRL, rd); check("post_rst_ctrl", rd, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
